if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/rv32i_types.sv | 35 +++
 rtl/fetch_buffer.sv | 32 +++
 rtl/if_stage.sv | 208 ++++++++++++++++++++
 tb/tb_if_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types used by the fetch stage and its neighbours.
// RVFI fields are only populated when IF_RVFI_EN is defined (see if_stage).
package rv32i_types;

  typedef enum logic {
    pc_next   = 1'b0,
    pc_offset = 1'b1
  } pc_mux_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
  } rvfi_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] inst;
    rvfi_t       rvfi;
  } if_stage_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry skid buffer holding a fetched word while decode stalls.
// A simultaneous push and pop replaces the entry; clear wins over both.
module fetch_buffer
  import rv32i_types::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_data,
  output logic         valid,
  output fetch_entry_t data
);

  // Entry storage and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (push) begin
      valid <= 1'b1;
      data  <= push_data;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, redirect/flush handling,
// skid buffer for decode stalls. Define IF_RVFI_EN to populate the rvfi fields.
module if_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pc_mux_t     i_pc_mux,
  input  logic [31:0] i_pc_imm,
  input  logic        i_flush,
  input  logic        if_reg_we,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  output if_stage_t   if_stage_reg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d, addr_d, redirect_pc;
  logic [3:0]   rmask_d;
  logic         redirect, live, adv, fb_full_next, can_issue;
  logic         fb_push, fb_pop, fb_valid, load_valid;
  fetch_entry_t fb_data, resp_entry, load_entry;
  if_stage_t    stage_d;

  assign redirect    = i_flush && (i_pc_mux == pc_offset);
  assign redirect_pc = redirect ? i_pc_imm : pc_q;
  assign live        = (state_q == WAIT) && imem_resp && !i_flush;
  // An empty stage register fills even while decode is stalled.
  assign adv         = if_reg_we || !if_stage_reg.valid;
  assign resp_entry  = '{pc: pc_q, inst: imem_rdata};

  assign fb_push      = live && (fb_valid || !adv);
  assign fb_pop       = !i_flush && adv && fb_valid;
  assign fb_full_next = live ? (fb_valid || !adv) : (fb_valid && !adv && !i_flush);
  assign can_issue    = !fb_full_next;

  fetch_buffer u_fetch_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (i_flush),
    .push      (fb_push),
    .pop       (fb_pop),
    .push_data (resp_entry),
    .valid     (fb_valid),
    .data      (fb_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        state_d = can_issue ? WAIT : IDLE;
      end
      WAIT: begin
        if (imem_resp) begin
          state_d = (i_flush || can_issue) ? WAIT : IDLE;
        end else if (i_flush) begin
          state_d = DISCARD;
        end else begin
          state_d = WAIT;
        end
      end
      DISCARD: begin
        state_d = imem_resp ? IDLE : DISCARD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs: next fetch pc and request address/mask
  always_comb begin
    pc_d    = pc_q;
    addr_d  = imem_addr;
    rmask_d = imem_rmask;
    case (state_q)
      IDLE: begin
        pc_d = redirect_pc;
        if (can_issue) begin
          addr_d  = redirect_pc;
          rmask_d = 4'hf;
        end else begin
          rmask_d = 4'h0;
        end
      end
      WAIT: begin
        if (imem_resp && i_flush) begin
          pc_d    = redirect_pc;
          addr_d  = redirect_pc;
          rmask_d = 4'hf;
        end else if (imem_resp) begin
          pc_d = seq_pc(pc_q);
          if (can_issue) begin
            addr_d  = seq_pc(pc_q);
            rmask_d = 4'hf;
          end else begin
            rmask_d = 4'h0;
          end
        end else begin
          // Without a redirect a flushed fetch is simply re-requested.
          pc_d = redirect_pc;
        end
      end
      DISCARD: begin
        pc_d    = redirect_pc;
        rmask_d = imem_resp ? 4'h0 : 4'hf;
      end
      default: begin
        pc_d    = RESET_PC;
        addr_d  = RESET_PC;
        rmask_d = 4'h0;
      end
    endcase
  end

  // Fetch pc and imem request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      imem_addr  <= RESET_PC;
      imem_rmask <= 4'h0;
    end else begin
      pc_q       <= pc_d;
      imem_addr  <= addr_d;
      imem_rmask <= rmask_d;
    end
  end

`ifdef IF_RVFI_EN
  logic [63:0] order_q;
  logic        accept;

  assign accept = if_stage_reg.valid && if_reg_we && !i_flush;

  // Retire-order counter, advanced per instruction handed to decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order_q <= 64'd0;
    end else if (accept) begin
      order_q <= order_q + 64'd1;
    end
  end
`endif

  // Select the next stage-register contents: buffered word first, then live response
  always_comb begin
    load_valid = 1'b0;
    load_entry = '0;
    stage_d    = '0;
    if (fb_valid) begin
      load_valid = 1'b1;
      load_entry = fb_data;
    end else if (live) begin
      load_valid = 1'b1;
      load_entry = resp_entry;
    end else begin
      load_valid = 1'b0;
    end
    if (load_valid) begin
      stage_d.valid   = 1'b1;
      stage_d.pc      = load_entry.pc;
      stage_d.pc_next = seq_pc(load_entry.pc);
      stage_d.inst    = load_entry.inst;
`ifdef IF_RVFI_EN
      stage_d.rvfi.valid    = 1'b1;
      stage_d.rvfi.order    = order_q + {63'd0, accept};
      stage_d.rvfi.inst     = load_entry.inst;
      stage_d.rvfi.pc_rdata = load_entry.pc;
      stage_d.rvfi.pc_wdata = seq_pc(load_entry.pc);
`endif
    end else begin
      stage_d = '0;
    end
  end

  // Stage register towards decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_stage_reg <= '0;
    end else if (i_flush) begin
      if_stage_reg <= '0;
    end else if (adv) begin
      if_stage_reg <= stage_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: bench-side memory plus a transaction-level
// model (fetch pc, queue of fetched words, delivered count) checked every cycle.
module tb_if_stage;
  import rv32i_types::*;

  localparam logic [31:0] RST_PC = 32'h1eceb000;

  logic        clk = 1'b0;
  logic        rst_n;
  pc_mux_t     i_pc_mux;
  logic [31:0] i_pc_imm;
  logic        i_flush;
  logic        if_reg_we;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  if_stage_t   if_stage_reg;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_pc_mux     (i_pc_mux),
    .i_pc_imm     (i_pc_imm),
    .i_flush      (i_flush),
    .if_reg_we    (if_reg_we),
    .imem_addr    (imem_addr),
    .imem_rmask   (imem_rmask),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .if_stage_reg (if_stage_reg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } word_t;

  int          checks = 0;
  int          failures = 0;
  word_t       q[$];
  word_t       m_out;
  bit          m_out_v;
  logic [31:0] m_pc;
  longint      m_delivered;
  bit          outstanding;
  bit          killed;
  logic [31:0] req_addr;
  int          wait_cnt;
  int          lat;
  int          idle_run;
  int          n_req = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_out_v     = 1'b0;
    m_pc        = RST_PC;
    m_delivered = 0;
    outstanding = 1'b0;
    killed      = 1'b0;
    idle_run    = 0;
  endtask

  task automatic compare_outputs();
    chk("out_valid", 64'(if_stage_reg.valid), 64'(m_out_v));
    if (m_out_v) begin
      chk("out_pc", 64'(if_stage_reg.pc), 64'(m_out.pc));
      chk("out_pc_next", 64'(if_stage_reg.pc_next), 64'(m_out.pc + 32'd4));
      chk("out_inst", 64'(if_stage_reg.inst), 64'(m_out.inst));
    end
`ifdef IF_RVFI_EN
    chk("rvfi_valid", 64'(if_stage_reg.rvfi.valid), 64'(m_out_v));
    if (m_out_v) begin
      chk("rvfi_order", if_stage_reg.rvfi.order, 64'(m_delivered));
      chk("rvfi_inst", 64'(if_stage_reg.rvfi.inst), 64'(m_out.inst));
      chk("rvfi_pc_rdata", 64'(if_stage_reg.rvfi.pc_rdata), 64'(m_out.pc));
      chk("rvfi_pc_wdata", 64'(if_stage_reg.rvfi.pc_wdata), 64'(m_out.pc + 32'd4));
    end
`else
    chk("rvfi_zero", 64'(if_stage_reg.rvfi == '0), 64'd1);
`endif
  endtask

  // One clock cycle: check at negedge, act as memory, drive inputs, advance the model.
  task automatic cycle(input bit flush, input bit offset, input logic [31:0] imm,
                       input bit we, input int resp_mode);
    @(negedge clk);
    compare_outputs();
    if (outstanding) begin
      chk("addr_stable", 64'(imem_addr), 64'(req_addr));
      chk("rmask_busy", 64'(imem_rmask), 64'hf);
      wait_cnt++;
    end else if (imem_rmask == 4'hf) begin
      chk("fetch_addr", 64'(imem_addr), 64'(m_pc));
      chk("issue_room", 64'(q.size()), 64'd0);
      outstanding = 1'b1;
      killed      = 1'b0;
      req_addr    = imem_addr;
      wait_cnt    = 0;
      lat         = (resp_mode == 2) ? $urandom_range(0, 3) : 0;
      n_req++;
    end else begin
      chk("rmask_idle", 64'(imem_rmask), 64'h0);
    end
    idle_run = (imem_rmask == 4'h0) ? idle_run + 1 : 0;
    if (idle_run > 20) begin
      checks++;
      failures++;
      $display("FAIL fetch_progress idle_cycles=%0d required<=20", idle_run);
      idle_run = 0;
    end

    i_flush    = flush;
    i_pc_mux   = offset ? pc_offset : pc_next;
    i_pc_imm   = imm;
    if_reg_we  = we;
    imem_resp  = outstanding && (resp_mode == 1 || (resp_mode == 2 && wait_cnt >= lat));
    imem_rdata = (resp_mode == 1) ? 32'h00000013 : $urandom;

    if (imem_resp) begin
      if (!killed && !flush) begin
        q.push_back('{pc: req_addr, inst: imem_rdata});
        m_pc = req_addr + 32'd4;
      end
      outstanding = 1'b0;
    end
    if (flush) begin
      if (outstanding) killed = 1'b1;
      if (offset) m_pc = imm;
      q.delete();
      m_out_v = 1'b0;
    end else begin
      if (m_out_v && we) m_delivered++;
      if (we || !m_out_v) begin
        if (q.size() > 0) begin
          m_out   = q.pop_front();
          m_out_v = 1'b1;
        end else begin
          m_out_v = 1'b0;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] r;
    rst_n      = 1'b0;
    i_pc_mux   = pc_next;
    i_pc_imm   = 32'h0;
    i_flush    = 1'b0;
    if_reg_we  = 1'b1;
    imem_resp  = 1'b0;
    imem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_rmask", 64'(imem_rmask), 64'h0);
    chk("rst_addr", 64'(imem_addr), 64'h1eceb000);
    chk("rst_stage_zero", 64'(if_stage_reg == '0), 64'd1);
    model_reset();
    rst_n = 1'b1;

    // Back-to-back fetch with single-cycle memory
    cycle(0, 0, 32'h0, 1, 1);
    chk("seq_addr0", 64'(imem_addr), 64'h1eceb000);
    chk("seq_valid0", 64'(if_stage_reg.valid), 64'd0);
    cycle(0, 0, 32'h0, 1, 1);
    chk("seq_pc0", 64'(if_stage_reg.pc), 64'h1eceb000);
    chk("seq_inst0", 64'(if_stage_reg.inst), 64'h00000013);
    chk("seq_addr1", 64'(imem_addr), 64'h1eceb004);
    cycle(0, 0, 32'h0, 1, 1);
    chk("seq_pc1", 64'(if_stage_reg.pc), 64'h1eceb004);
    chk("seq_addr2", 64'(imem_addr), 64'h1eceb008);

    // Flush with redirect while waiting; stale response arrives three cycles later
    cycle(1, 1, 32'h1eceb100, 1, 0);
    cycle(0, 0, 32'h0, 1, 0);
    chk("discard_valid", 64'(if_stage_reg.valid), 64'd0);
    chk("discard_addr", 64'(imem_addr), 64'h1eceb00c);
    cycle(0, 0, 32'h0, 1, 0);
    cycle(0, 0, 32'h0, 1, 1);
    cycle(0, 0, 32'h0, 1, 1);
    chk("dropped_valid", 64'(if_stage_reg.valid), 64'd0);
    chk("dropped_rmask", 64'(imem_rmask), 64'h0);
    cycle(0, 0, 32'h0, 1, 1);
    chk("redirect_addr", 64'(imem_addr), 64'h1eceb100);

    // Flush coincident with a response
    cycle(1, 1, 32'h1eceb200, 1, 1);
    chk("redirect_pc", 64'(if_stage_reg.pc), 64'h1eceb100);
    cycle(0, 0, 32'h0, 1, 0);
    chk("coinc_valid", 64'(if_stage_reg.valid), 64'd0);
    chk("coinc_addr", 64'(imem_addr), 64'h1eceb200);

    // Decode stall across two responses
    cycle(0, 0, 32'h0, 0, 1);
    cycle(0, 0, 32'h0, 0, 1);
    chk("stall_pc_a", 64'(if_stage_reg.pc), 64'h1eceb200);
    cycle(0, 0, 32'h0, 0, 1);
    chk("stall_no_req", 64'(imem_rmask), 64'h0);
    chk("stall_pc_b", 64'(if_stage_reg.pc), 64'h1eceb200);
    cycle(0, 0, 32'h0, 1, 1);
    chk("stall_no_req2", 64'(imem_rmask), 64'h0);
    cycle(0, 0, 32'h0, 1, 0);
    chk("release_pc", 64'(if_stage_reg.pc), 64'h1eceb204);
    chk("release_addr", 64'(imem_addr), 64'h1eceb208);

    // Reset while a request is outstanding, with a late response after release
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rmask", 64'(imem_rmask), 64'h0);
    chk("midrst_addr", 64'(imem_addr), 64'h1eceb000);
    chk("midrst_stage_zero", 64'(if_stage_reg == '0), 64'd1);
    @(negedge clk);
    imem_resp  = 1'b1;
    imem_rdata = 32'hdeadbeef;
    i_flush    = 1'b0;
    if_reg_we  = 1'b1;
    model_reset();
    rst_n = 1'b1;
    cycle(0, 0, 32'h0, 1, 0);
    chk("restart_addr", 64'(imem_addr), 64'h1eceb000);
    chk("restart_valid", 64'(if_stage_reg.valid), 64'd0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      cycle($urandom_range(0, 99) < 6, $urandom_range(0, 1) == 1, r & 32'hffff_fffc,
            $urandom_range(0, 99) < 70, 2);
    end
    chk("enough_requests", 64'(n_req > 300), 64'd1);
    chk("enough_delivered", 64'(m_delivered > 150), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
